// File: rtl/tx_burst_generator_if.sv
// TX FIFO write-side bundle between the burst generator and the core TX FIFO.
interface tx_burst_generator_if;
  logic        tx_full;
  logic [31:0] tx_data;
  logic        tx_write;

  modport master (input tx_full, output tx_data, output tx_write);
  modport slave  (output tx_full, input tx_data, input tx_write);
endinterface

// File: rtl/tx_burst_generator.sv
// tx_burst_generator: debounced push-button starts a framed burst of 32-bit
// words (header, BURST_LEN sequence-numbered payload words, optional checksum
// trailer) written into the TX FIFO while honouring its almost-full flag.
// Optional feature macro: TX_CHECKSUM_EN adds a modulo-2^32 checksum trailer.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a debounced 0->1 trigger edge
// HEADER   | emit {HEADER_MAGIC, burst_count}
// PAYLOAD  | emit {burst_count, index} for index 0..BURST_LEN-1
// TRAILER  | emit checksum of header+payload (TX_CHECKSUM_EN only)
// DONE     | bump burst_count, drop busy, return to IDLE
module tx_burst_generator #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned BURST_LEN       = 256,
  parameter logic [15:0] HEADER_MAGIC    = 16'hA5A5
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        trigger,
  tx_burst_generator_if.master        tx,
  output logic                        busy,
  output logic [15:0]                 burst_count
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HEADER  = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
`ifdef TX_CHECKSUM_EN
  localparam logic [2:0] ST_TRAILER = 3'd3;
`endif
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [23:0] DEB_LAST = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] IDX_LAST = 16'(BURST_LEN - 1);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic [23:0] deb_cnt_q, deb_cnt_d;
  logic        deb_level_q, deb_level_d;
  logic        deb_prev_q, deb_prev_d;
  logic [2:0]  state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] tx_data_q, tx_data_d;
  logic        tx_write_q, tx_write_d;
  logic        busy_q, busy_d;
  logic [15:0] count_q, count_d;
`ifdef TX_CHECKSUM_EN
  logic [31:0] acc_q, acc_d;
`endif

  logic        start_evt;
  logic [31:0] header_word;
  logic [31:0] payload_word;

  assign start_evt    = deb_level_q & ~deb_prev_q;
  assign header_word  = {HEADER_MAGIC, count_q};
  assign payload_word = {count_q, idx_q};

  // Synchroniser and debounce: level follows the synchronised input only after
  // it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    sync1_d     = trigger;
    sync2_d     = sync1_q;
    deb_cnt_d   = '0;
    deb_level_d = deb_level_q;
    deb_prev_d  = deb_level_q;
    if (sync2_q != deb_level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_level_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 24'd1;
      end
    end
  end

  // Burst sequencing; each emitting state writes one word per cycle unless the
  // FIFO reports almost-full, in which case it holds without advancing.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_write_d = 1'b0;
    busy_d     = busy_q;
    count_d    = count_q;
`ifdef TX_CHECKSUM_EN
    acc_d      = acc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_evt) begin
          state_d = ST_HEADER;
          busy_d  = 1'b1;
`ifdef TX_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      ST_HEADER: begin
        if (!tx.tx_full) begin
          tx_write_d = 1'b1;
          tx_data_d  = header_word;
          idx_d      = '0;
          state_d    = ST_PAYLOAD;
`ifdef TX_CHECKSUM_EN
          acc_d      = acc_q + header_word;
`endif
        end
      end
      ST_PAYLOAD: begin
        if (!tx.tx_full) begin
          tx_write_d = 1'b1;
          tx_data_d  = payload_word;
`ifdef TX_CHECKSUM_EN
          acc_d      = acc_q + payload_word;
`endif
          if (idx_q == IDX_LAST) begin
`ifdef TX_CHECKSUM_EN
            state_d = ST_TRAILER;
`else
            state_d = ST_DONE;
`endif
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
      end
`ifdef TX_CHECKSUM_EN
      ST_TRAILER: begin
        if (!tx.tx_full) begin
          tx_write_d = 1'b1;
          tx_data_d  = acc_q;
          state_d    = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        count_d = count_q + 16'd1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-high reset; reset aborts any burst.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_cnt_q   <= '0;
      deb_level_q <= 1'b0;
      deb_prev_q  <= 1'b0;
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      tx_data_q   <= '0;
      tx_write_q  <= 1'b0;
      busy_q      <= 1'b0;
      count_q     <= '0;
`ifdef TX_CHECKSUM_EN
      acc_q       <= '0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_cnt_q   <= deb_cnt_d;
      deb_level_q <= deb_level_d;
      deb_prev_q  <= deb_prev_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      tx_data_q   <= tx_data_d;
      tx_write_q  <= tx_write_d;
      busy_q      <= busy_d;
      count_q     <= count_d;
`ifdef TX_CHECKSUM_EN
      acc_q       <= acc_d;
`endif
    end
  end

  assign tx.tx_data   = tx_data_q;
  assign tx.tx_write  = tx_write_q;
  assign busy         = busy_q;
  assign burst_count  = count_q;

endmodule

// File: tb/tb_tx_burst_generator.sv
// Directed bench for tx_burst_generator with DEBOUNCE_CYCLES=4, BURST_LEN=4.
module tb_tx_burst_generator;

`ifdef TX_CHECKSUM_EN
  localparam int NW = 6;
`else
  localparam int NW = 5;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        trigger;
  logic        busy;
  logic [15:0] burst_count;

  tx_burst_generator_if tx_if ();

  tx_burst_generator #(
    .DEBOUNCE_CYCLES(4),
    .BURST_LEN      (4),
    .HEADER_MAGIC   (16'hA5A5)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .trigger    (trigger),
    .tx         (tx_if),
    .busy       (busy),
    .burst_count(burst_count)
  );

  always #5 clk_in = ~clk_in;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc   = 0;
  logic [31:0] wq[$];
  int unsigned wc[$];

  // Record every written word and the cycle it was written in.
  always @(posedge clk_in) begin
    #1;
    cyc = cyc + 1;
    if (tx_if.tx_write === 1'b1) begin
      wq.push_back(tx_if.tx_data);
      wc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic pulse(input int n);
    trigger = 1'b1;
    cycles(n);
    trigger = 1'b0;
  endtask

  task automatic wait_words(input int n, input int limit);
    int k = 0;
    while (wq.size() < n && k < limit) begin
      cycles(1);
      k++;
    end
    check("wait_words_timeout", 32'(wq.size() >= n), 32'd1);
  endtask

  task automatic check_burst(input logic [15:0] bc, input bit contiguous);
    logic [31:0] w;
    logic [31:0] sum;
    check("burst_words", 32'(wq.size()), 32'(NW));
    if (wq.size() == NW) begin
      w = {16'hA5A5, bc};
      check("header", wq[0], w);
      sum = w;
      for (int i = 0; i < 4; i++) begin
        w = {bc, 16'(i)};
        check("payload", wq[1 + i], w);
        sum = sum + w;
      end
`ifdef TX_CHECKSUM_EN
      check("trailer", wq[5], sum);
`endif
      if (contiguous) check("back_to_back", wc[NW - 1] - wc[0], 32'(NW - 1));
    end
    wq.delete();
    wc.delete();
  endtask

  initial begin
    rst_in        = 1'b1;
    trigger       = 1'b0;
    tx_if.tx_full = 1'b0;
    cycles(3);
    check("rst_data",  tx_if.tx_data, 32'h0);
    check("rst_write", 32'(tx_if.tx_write), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_count", 32'(burst_count), 32'd0);
    rst_in = 1'b0;
    cycles(2);

    // Glitch shorter than the debounce window: no burst.
    pulse(3);
    cycles(20);
    check("glitch_words", 32'(wq.size()), 32'd0);
    check("glitch_busy",  32'(busy), 32'd0);

    // Clean pulse: header plus four payload words, back to back.
    pulse(10);
    wait_words(NW, 60);
    cycles(3);
    check_burst(16'd0, 1'b1);
    check("clean_count", 32'(burst_count), 32'd1);
    check("clean_busy",  32'(busy), 32'd0);
    cycles(10);

    // Bouncing trigger: high 3, low 1, high 10 gives exactly one burst.
    trigger = 1'b1;
    cycles(3);
    trigger = 1'b0;
    cycles(1);
    pulse(10);
    wait_words(NW, 60);
    cycles(3);
    check_burst(16'd1, 1'b1);
    cycles(20);
    check("bounce_single", 32'(wq.size()), 32'd0);
    check("bounce_count",  32'(burst_count), 32'd2);

    // Back-pressure for 5 cycles after payload index 1.
    trigger = 1'b1;
    wait_words(3, 60);
    tx_if.tx_full = 1'b1;
    trigger = 1'b0;
    cycles(2);
    check("stall_write", 32'(tx_if.tx_write), 32'd0);
    cycles(3);
    check("stall_words", 32'(wq.size()), 32'd3);
    tx_if.tx_full = 1'b0;
    wait_words(NW, 60);
    cycles(3);
    if (wc.size() >= 4) check("stall_gap", wc[3] - wc[2], 32'd6);
    check_burst(16'd2, 1'b0);
    check("stall_count", 32'(burst_count), 32'd3);
    cycles(10);

    // Second trigger while busy is dropped (header held off by tx_full).
    tx_if.tx_full = 1'b1;
    pulse(8);
    cycles(20);
    check("held_busy",  32'(busy), 32'd1);
    check("held_words", 32'(wq.size()), 32'd0);
    pulse(8);
    cycles(20);
    check("held2_busy", 32'(busy), 32'd1);
    tx_if.tx_full = 1'b0;
    wait_words(NW, 60);
    cycles(3);
    check_burst(16'd3, 1'b1);
    cycles(30);
    check("dropped_edge", 32'(wq.size()), 32'd0);
    check("dropped_count", 32'(burst_count), 32'd4);

    // Reset mid-burst after payload index 2 is written.
    trigger = 1'b1;
    wait_words(4, 60);
    rst_in  = 1'b1;
    trigger = 1'b0;
    cycles(1);
    check("mid_rst_write", 32'(tx_if.tx_write), 32'd0);
    check("mid_rst_data",  tx_if.tx_data, 32'h0);
    check("mid_rst_busy",  32'(busy), 32'd0);
    check("mid_rst_count", 32'(burst_count), 32'd0);
    rst_in = 1'b0;
    cycles(20);
    check("mid_rst_no_more", 32'(wq.size()), 32'd4);
    wq.delete();
    wc.delete();
    pulse(10);
    wait_words(NW, 60);
    cycles(3);
    check_burst(16'd0, 1'b1);
    check("post_rst_count", 32'(burst_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tx_burst_generator.md
Name: tx_burst_generator

Overview:
- Upstream stage of the FT245 transmit path; produces the 32-bit word stream written into the core TX FIFO (tx_data/tx_write).
- A debounced push-button edge starts one framed burst: header, BURST_LEN sequence-numbered payload words, and an optional checksum trailer.
- Honours FIFO back-pressure and keeps a running burst counter, giving host-side software a deterministic pattern for throughput and loss checks.

Parameters:
- DEBOUNCE_CYCLES, 270000, cycles trigger must be stable before accepted (10 ms at 27 MHz); legal range 2..2^24-1.
- BURST_LEN, 256, payload words per burst; legal range 1..65535.
- HEADER_MAGIC, 16'hA5A5, upper half of every header word.

Ports:
- clk_in  input  1  generator clock, same domain as the TX FIFO write side.
- rst_in  input  1  synchronous reset, active-high.
- trigger  input  1  raw asynchronous push-button, active-high.
- tx_full  input  1  TX FIFO almost-full; at least 1 free slot remains when first asserted.
- tx_data  output  32  word to FIFO, valid when tx_write=1.
- tx_write  output  1  one-cycle write strobe per word.
- busy  output  1  high from burst start until return to IDLE.
- burst_count  output  16  number of completed bursts, wraps.

Behaviour:
- Reset (rst_in sampled high on a clk_in edge) clears tx_data=0, tx_write=0, busy=0, burst_count=0, state=IDLE, debounce counter=0, synchroniser flops=0, debounced level=0.
- Reset mid-burst aborts immediately; words already written stay in the FIFO, and no trailer is sent.
- trigger passes through a 2-FF synchroniser. The debounced level updates only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
- Start event = 0->1 transition of the debounced level.
  - Accepted only in IDLE.
  - Edges arriving while busy=1 are dropped, not queued.
- FSM states: IDLE, HEADER, PAYLOAD, TRAILER (only with macro), DONE.
  - IDLE -> HEADER on start event; busy goes high on the same edge.
  - HEADER -> PAYLOAD once the header word is emitted.
  - PAYLOAD -> TRAILER (macro) or DONE after word index BURST_LEN-1 is emitted.
  - TRAILER -> DONE once the trailer is emitted.
  - DONE -> IDLE after exactly 1 cycle. In DONE, burst_count increments (0xFFFF -> 0x0000) and busy clears on exit.
- Emission rule:
  - In an emitting state with tx_full=0, the next edge registers tx_write=1 and tx_data=word, and the FSM/index advances.
  - With tx_full=1, the next edge registers tx_write=0 and there is no advance.
  - The 1-cycle registered latency is why tx_full must be an almost-full with 1 slot of slack.
- Words (burst_count is the value before increment):
  - Header = {HEADER_MAGIC, burst_count}.
  - Payload i (i=0..BURST_LEN-1) = {burst_count, i[15:0]}.
- tx_write can be held high on consecutive cycles (1 word/cycle) while tx_full=0. tx_data holds its last value when tx_write=0.

Optional Feature:
- Macro TX_CHECKSUM_EN.
- Defined:
  - A 32-bit accumulator clears in HEADER entry and sums every emitted header and payload word modulo 2^32.
  - The TRAILER state emits the accumulator value.
  - A burst is BURST_LEN+2 words.
- Undefined: no accumulator logic, no TRAILER state, and a burst is BURST_LEN+1 words.

Test Plan:
- DEBOUNCE_CYCLES=4, BURST_LEN=4, tx_full=0, clean trigger pulse -> exactly 5 consecutive writes: 0xA5A50000, 0x00000000, 0x00000001, 0x00000002, 0x00000003; then burst_count=1 and busy=0.
- Bouncing trigger (high 3 cycles, low 1, high 10) with DEBOUNCE_CYCLES=4 -> exactly one burst; a glitch shorter than 4 cycles yields no writes.
- tx_full held high for 5 cycles starting mid-payload -> tx_write=0 for those cycles with no index skip or duplicate; the sequence resumes at the next index.
- Second trigger during a burst -> ignored. A trigger after busy falls -> header 0xA5A50001 and payload 0x00010000...
- TX_CHECKSUM_EN, BURST_LEN=2, burst_count=0 -> words 0xA5A50000, 0x00000000, 0x00000001, trailer 0xA5A50001.
- rst_in pulsed at payload index 2 -> next cycle all outputs 0 and state IDLE; a new trigger restarts from the header with burst_count=0.
